// File: rtl/lif_neuron_bank.sv
// Multi-channel spiking neuron bank: divider (wrap) mode and leaky integrate-and-fire mode,
// with registered spike pulses, per-channel spike counters and a potential readback port.
module lif_neuron_bank #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned REFRACT_BITS = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned SEL_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic                         mode,
    input  logic [CHANNELS*WIDTH-1:0]    w,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [WIDTH-1:0]             leak,
    input  logic [REFRACT_BITS-1:0]      refractory,
    input  logic [SEL_BITS-1:0]          sel,
    output logic [CHANNELS-1:0]          spike,
    output logic [WIDTH-1:0]             potential,
    output logic [CNT_WIDTH-1:0]         spike_count
);

    localparam logic [WIDTH-1:0] V_MAX = '1;

    logic [WIDTH-1:0]     v_arr   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_arr [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0]        w_ch;
        logic [WIDTH-1:0]        v_q;
        logic [WIDTH-1:0]        v_d;
        logic [WIDTH-1:0]        sat;
        logic [WIDTH:0]          sum;
        logic [REFRACT_BITS-1:0] r_q;
        logic [REFRACT_BITS-1:0] r_d;
        logic [CNT_WIDTH-1:0]    cnt_q;
        logic                    fire;
        logic                    spike_q;

        assign w_ch = w[i*WIDTH +: WIDTH];

        // Next potential, refractory count and fire decision for one enabled tick.
        always_comb begin
            v_d  = v_q;
            r_d  = r_q;
            fire = 1'b0;
            sum  = {1'b0, v_q} + {1'b0, w_ch};
            sat  = sum[WIDTH] ? V_MAX : sum[WIDTH-1:0];
            if (!mode) begin
                v_d  = sum[WIDTH-1:0];
                fire = sum[WIDTH];
                r_d  = '0;
            end else if (r_q != '0) begin
                r_d = r_q - REFRACT_BITS'(1);
            end else if (sat >= threshold) begin
                fire = 1'b1;
                v_d  = '0;
                r_d  = refractory;
            end else begin
                v_d = (sat > leak) ? (sat - leak) : '0;
            end
        end

        // Channel state: reset > clear > enabled tick; spike pulse only after a firing tick.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q     <= '0;
                r_q     <= '0;
                cnt_q   <= '0;
                spike_q <= 1'b0;
            end else if (clear) begin
                v_q     <= '0;
                r_q     <= '0;
                spike_q <= 1'b0;
            end else if (en) begin
                v_q     <= v_d;
                r_q     <= r_d;
                cnt_q   <= cnt_q + CNT_WIDTH'(fire);
                spike_q <= fire;
            end else begin
                spike_q <= 1'b0;
            end
        end

        assign spike[i]   = spike_q;
        assign v_arr[i]   = v_q;
        assign cnt_arr[i] = cnt_q;
    end

    // Debug readback of the selected channel; out-of-range selects read zero.
    always_comb begin
        potential   = '0;
        spike_count = '0;
        if (32'(sel) < CHANNELS) begin
            potential   = v_arr[sel];
            spike_count = cnt_arr[sel];
        end
    end

endmodule

// File: tb/tb_lif_neuron_bank.sv
// Randomized and directed checks of lif_neuron_bank against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lif_neuron_bank;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned CHANNELS     = 4;
    localparam int unsigned REFRACT_BITS = 4;
    localparam int unsigned CNT_WIDTH    = 4;
    localparam int unsigned SEL_BITS     = 2;
    localparam int VMAX = (1 << WIDTH) - 1;
    localparam int CMOD = 1 << CNT_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      clear;
    logic                      mode;
    logic [CHANNELS*WIDTH-1:0] w;
    logic [WIDTH-1:0]          threshold;
    logic [WIDTH-1:0]          leak;
    logic [REFRACT_BITS-1:0]   refractory;
    logic [SEL_BITS-1:0]       sel;
    logic [CHANNELS-1:0]       spike;
    logic [WIDTH-1:0]          potential;
    logic [CNT_WIDTH-1:0]      spike_count;

    int n_vec = 0;
    int n_err = 0;

    int mv [CHANNELS];
    int mr [CHANNELS];
    int mc [CHANNELS];
    int ms [CHANNELS];

    lif_neuron_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .REFRACT_BITS(REFRACT_BITS),
        .CNT_WIDTH(CNT_WIDTH), .SEL_BITS(SEL_BITS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .w(w),
        .threshold(threshold), .leak(leak), .refractory(refractory), .sel(sel),
        .spike(spike), .potential(potential), .spike_count(spike_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            mv[i] = 0; mr[i] = 0; mc[i] = 0; ms[i] = 0;
        end
    endtask

    // One clock edge of the behavioural neuron rules.
    task automatic model_step();
        int wi, s, f;
        for (int i = 0; i < CHANNELS; i++) begin
            f = 0;
            if (clear) begin
                mv[i] = 0; mr[i] = 0;
            end else if (en) begin
                wi = int'(w[i*WIDTH +: WIDTH]);
                if (!mode) begin
                    s = mv[i] + wi;
                    f = (s > VMAX) ? 1 : 0;
                    mv[i] = s % (VMAX + 1);
                    mr[i] = 0;
                end else if (mr[i] > 0) begin
                    mr[i] = mr[i] - 1;
                end else begin
                    s = (mv[i] + wi > VMAX) ? VMAX : mv[i] + wi;
                    if (s >= int'(threshold)) begin
                        f = 1; mv[i] = 0; mr[i] = int'(refractory);
                    end else begin
                        mv[i] = (s > int'(leak)) ? s - int'(leak) : 0;
                    end
                end
                mc[i] = (mc[i] + f) % CMOD;
            end
            ms[i] = f;
        end
    endtask

    task automatic check_all(input string tag);
        int exp_sp;
        exp_sp = 0;
        for (int i = 0; i < CHANNELS; i++) exp_sp |= ms[i] << i;
        check({tag, ".spike"}, int'(spike), exp_sp);
        for (int i = 0; i < CHANNELS; i++) begin
            sel = SEL_BITS'(i);
            #1;
            check($sformatf("%s.v%0d", tag, i), int'(potential), mv[i]);
            check($sformatf("%s.cnt%0d", tag, i), int'(spike_count), mc[i]);
        end
        sel = '0;
        #1;
    endtask

    task automatic tick(input logic e, input logic c, input string tag);
        en = e; clear = c;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_w(input int w3, input int w2, input int w1, input int w0);
        w = {WIDTH'(w3), WIDTH'(w2), WIDTH'(w1), WIDTH'(w0)};
    endtask

    int exp_v1 [5] = '{191, 126, 61, 252, 187};
    int exp_s1 [5] = '{0, 1, 1, 0, 1};

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0; mode = 1'b0; sel = '0;
        w = '0; threshold = '0; leak = '0; refractory = '0;
        model_reset();

        // Test 1: divider mode, four weights.
        do_reset();
        set_w(255, 128, 0, 191);
        for (int t = 0; t < 6; t++) begin
            tick(1'b1, 1'b0, "div");
            if (t < 5) begin
                check($sformatf("div_v0_t%0d", t + 1), int'(dut.v_arr[0]), exp_v1[t]);
                check($sformatf("div_sp0_t%0d", t + 1), int'(spike[0]), exp_s1[t]);
            end
            if (t >= 1) check($sformatf("div_sp3_t%0d", t + 1), int'(spike[3]), 1);
            check($sformatf("div_sp1_t%0d", t + 1), int'(spike[1]), 0);
        end

        // Test 2: LIF mode with leak and refractory.
        do_reset();
        mode = 1'b1; set_w(0, 0, 0, 40); threshold = 100; leak = 5; refractory = 2;
        for (int t = 1; t <= 13; t++) begin
            tick(1'b1, 1'b0, "lif");
            if (t == 1) check("lif_v_t1", int'(potential), 35);
            if (t == 2) check("lif_v_t2", int'(potential), 70);
            if (t == 3 || t == 8 || t == 13) check($sformatf("lif_sp_t%0d", t), int'(spike[0]), 1);
            if (t == 5) check("lif_v_refr", int'(potential), 0);
            if (t == 6) check("lif_v_t6", int'(potential), 35);
            if (t == 8) check("lif_cnt_t8", int'(spike_count), 2);
        end

        // Test 3: saturation at the top of range.
        do_reset();
        mode = 1'b1; set_w(0, 0, 0, 200); threshold = 255; leak = 0; refractory = 0;
        tick(1'b1, 1'b0, "sat");
        check("sat_v_t1", int'(potential), 200);
        check("sat_sp_t1", int'(spike[0]), 0);
        tick(1'b1, 1'b0, "sat");
        check("sat_sp_t2", int'(spike[0]), 1);
        check("sat_v_t2", int'(potential), 0);

        // Test 4: gating and clear.
        do_reset();
        mode = 1'b0; set_w(0, 0, 0, 100);
        tick(1'b1, 1'b0, "gate");
        tick(1'b1, 1'b0, "gate");
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, "hold");
        check("hold_v", int'(potential), 200);
        tick(1'b1, 1'b1, "clr");
        check("clr_v", int'(potential), 0);
        check("clr_sp", int'(spike[0]), 0);

        // Test 5: asynchronous reset between edges.
        do_reset();
        mode = 1'b0; set_w(0, 0, 0, 203);
        tick(1'b1, 1'b0, "ar");
        tick(1'b1, 1'b0, "ar");
        check("ar_pre_v", int'(potential), 150);
        check("ar_pre_sp", int'(spike[0]), 1);
        rst = 1'b0;
        model_reset();
        #1;
        check("ar_sp", int'(spike), 0);
        check("ar_v", int'(potential), 0);
        check("ar_cnt", int'(spike_count), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 1'b0, "ar_post");
        check("ar_post_v", int'(potential), 203);

        // Test 6: spike counter wrap.
        do_reset();
        mode = 1'b0; set_w(0, 0, 0, 128);
        for (int t = 0; t < 34; t++) tick(1'b1, 1'b0, "wrap");
        check("wrap_cnt", int'(spike_count), 1);

        // Randomized phase.
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if (t % 40 == 0) begin
                mode       = 1'($urandom_range(0, 1));
                threshold  = WIDTH'($urandom_range(0, 255));
                leak       = WIDTH'($urandom_range(0, 30));
                refractory = REFRACT_BITS'($urandom_range(0, 15));
            end
            if (t % 8 == 0) w = (CHANNELS*WIDTH)'($urandom);
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
